// File: rtl/spi_queue_writer.sv
`default_nettype none
// ============================================================================
// Module   : spi_queue_writer
// Purpose  : Drains the SPI write-request queue and the SPI data fifo. Each
//            request byte names a target device and a byte count. The block
//            fetches that many data bytes and shifts them out MSB first on a
//            mode-0 SPI bus under a single chip-select assertion. It then
//            reports success, or a data-underrun abort.
// Ports    :
//   clk                  system clock
//   rst                  asynchronous reset, active low
//   spi_en               allows new transactions to start
//   spiwr_queue_data_i   request byte: [7:6] device, [5:0] count-1
//   spiwr_queue_rd_en_o  request queue read strobe
//   spiwr_queue_empty_i  request queue empty flag
//   spi_data_i           data fifo output
//   spi_rd_en_o          data fifo read strobe
//   spi_fifo_empty_i     data fifo empty flag
//   sclk_o/mosi_o/miso_i SPI bus (mode 0, MSB first)
//   cs_n_o               active-low chip selects, one per device
//   rd_data_o            last complete byte captured from MISO
//   done_o               one-cycle end-of-transaction pulse
//   status_o             8'h00 success, 8'hE1 data underrun abort
//   busy_o               transaction in progress
// Revision : 1.0 - initial release
// ============================================================================
module spi_queue_writer #(
  parameter int CLK_DIV = 2,     // clk cycles per SCLK half-period, 1..255
  parameter int TIMEOUT = 1024   // wait cycles for a missing data byte, 1..65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_en,
  input  logic [7:0] spiwr_queue_data_i,
  output logic       spiwr_queue_rd_en_o,
  input  logic       spiwr_queue_empty_i,
  input  logic [7:0] spi_data_i,
  output logic       spi_rd_en_o,
  input  logic       spi_fifo_empty_i,
  output logic       sclk_o,
  output logic       mosi_o,
  input  logic       miso_i,
  output logic [3:0] cs_n_o,
  output logic [7:0] rd_data_o,
  output logic       done_o,
  output logic [7:0] status_o,
  output logic       busy_o
);

  localparam logic [7:0]  c_div_last   = 8'(CLK_DIV - 1);
  localparam logic [15:0] c_wait_last  = 16'(TIMEOUT - 1);
  localparam logic [7:0]  c_status_ok  = 8'h00;
  localparam logic [7:0]  c_status_udr = 8'hE1;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_REQ_RD    = 4'd1,
    S_REQ_LATCH = 4'd2,
    S_DAT_RD    = 4'd3,
    S_DAT_LATCH = 4'd4,
    S_SHIFT_LO  = 4'd5,
    S_SHIFT_HI  = 4'd6,
    S_CS_HOLD   = 4'd7,
    S_GAP       = 4'd8,
    S_ABORT     = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;        // clk cycles spent in the current timed phase
  logic [2:0] bit_q, bit_d;        // bit index within the current byte
  logic [6:0] bytes_q, bytes_d;    // bytes still to shift (1..64)
  logic [15:0] wait_q, wait_d;     // cycles spent waiting on an empty data fifo
  logic [1:0] dev_q, dev_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [3:0] cs_n_q, cs_n_d;
  logic [7:0] status_q, status_d;
  logic       sclk_q, sclk_d;

  logic       w_req_rd;
  logic       w_dat_rd;
  logic       w_done;
  logic       w_div_last;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      bytes_q   <= '0;
      wait_q    <= '0;
      dev_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      cs_n_q    <= 4'hF;
      status_q  <= c_status_ok;
      sclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      bytes_q   <= bytes_d;
      wait_q    <= wait_d;
      dev_q     <= dev_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      cs_n_q    <= cs_n_d;
      status_q  <= status_d;
      sclk_q    <= sclk_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and strobe logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    bytes_d   = bytes_q;
    wait_d    = wait_q;
    dev_d     = dev_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    cs_n_d    = cs_n_q;
    status_d  = status_q;
    w_req_rd  = 1'b0;
    w_dat_rd  = 1'b0;
    w_done    = 1'b0;
    w_div_last = (div_q == c_div_last);

    case (state_q)
      S_IDLE: begin
        if (spi_en && !spiwr_queue_empty_i) begin
          w_req_rd = 1'b1;
          state_d  = S_REQ_RD;
        end
      end

      // Request byte becomes valid at the fifo output during this cycle.
      S_REQ_RD: state_d = S_REQ_LATCH;

      S_REQ_LATCH: begin
        dev_d   = spiwr_queue_data_i[7:6];
        bytes_d = {1'b0, spiwr_queue_data_i[5:0]} + 7'd1;
        wait_d  = '0;
        state_d = S_DAT_RD;
      end

      S_DAT_RD: begin
        if (!spi_fifo_empty_i) begin
          w_dat_rd = 1'b1;
          wait_d   = '0;
          state_d  = S_DAT_LATCH;
        end else if (wait_q == c_wait_last) begin
          // Underrun: release the device now; ABORT reports it.
          cs_n_d   = 4'hF;
          status_d = c_status_udr;
          state_d  = S_ABORT;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      // Chip select and MOSI bit 7 appear together on the next cycle, so the
      // first SCLK rise follows chip select by a full half-period.
      S_DAT_LATCH: begin
        tx_d    = spi_data_i;
        cs_n_d  = ~(4'b0001 << dev_q);
        div_d   = '0;
        bit_d   = '0;
        state_d = S_SHIFT_LO;
      end

      S_SHIFT_LO: begin
        if (w_div_last) begin
          div_d   = '0;
          state_d = S_SHIFT_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_SHIFT_HI: begin
        // MISO is captured once, on the first high cycle.
        if (div_q == 8'd0) begin
          rx_d = {rx_q[6:0], miso_i};
        end
        if (w_div_last) begin
          div_d = '0;
          tx_d  = {tx_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            // rx_d already holds the final bit even when CLK_DIV is 1.
            rd_data_d = rx_d;
            bytes_d   = bytes_q - 7'd1;
            state_d   = (bytes_q == 7'd1) ? S_CS_HOLD : S_DAT_RD;
          end else begin
            state_d = S_SHIFT_LO;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_CS_HOLD: begin
        if (w_div_last) begin
          div_d    = '0;
          cs_n_d   = 4'hF;
          status_d = c_status_ok;
          state_d  = S_GAP;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_GAP: begin
        if (w_div_last) begin
          div_d   = '0;
          w_done  = 1'b1;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      // Remaining bytes of the aborted request stay in the fifo.
      S_ABORT: begin
        w_done  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    sclk_d = (state_d == S_SHIFT_HI);
  end

  // --------------------------------------------------------------------------
  // Outputs. The fifo strobes are gated by reset so that a held reset can
  // never pop a fifo, even though the IDLE decode is combinational.
  // --------------------------------------------------------------------------
  assign spiwr_queue_rd_en_o = w_req_rd & rst;
  assign spi_rd_en_o         = w_dat_rd & rst;
  assign sclk_o              = sclk_q;
  assign mosi_o              = tx_q[7];
  assign cs_n_o              = cs_n_q;
  assign rd_data_o           = rd_data_q;
  assign done_o              = w_done;
  assign status_o            = status_q;
  assign busy_o              = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_queue_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_queue_writer
// Purpose  : Scoreboard bench for spi_queue_writer. Stimulus pushes expected
//            transaction results into a queue; a monitor rebuilds each
//            transaction from the pins and compares it on every done_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_queue_writer;

  localparam int CLK_DIV = 2;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       spi_en = 1'b0;
  logic [7:0] req_dout = 8'h00;
  logic       req_rd;
  logic       req_empty = 1'b1;
  logic [7:0] dat_dout = 8'h00;
  logic       dat_rd;
  logic       dat_empty = 1'b1;
  logic       sclk, mosi;
  logic       miso = 1'b0;
  logic [3:0] cs_n;
  logic [7:0] rd_data, status;
  logic       done, busy;

  always #5 clk = ~clk;

  spi_queue_writer #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .spi_en              (spi_en),
    .spiwr_queue_data_i  (req_dout),
    .spiwr_queue_rd_en_o (req_rd),
    .spiwr_queue_empty_i (req_empty),
    .spi_data_i          (dat_dout),
    .spi_rd_en_o         (dat_rd),
    .spi_fifo_empty_i    (dat_empty),
    .sclk_o              (sclk),
    .mosi_o              (mosi),
    .miso_i              (miso),
    .cs_n_o              (cs_n),
    .rd_data_o           (rd_data),
    .done_o              (done),
    .status_o            (status),
    .busy_o              (busy)
  );

  // ---------------- standard-read fifo models ----------------
  logic [7:0] req_q[$];
  logic [7:0] dat_q[$];

  always @(posedge clk) begin
    if (req_rd && req_q.size() != 0) req_dout <= req_q.pop_front();
    if (dat_rd && dat_q.size() != 0) dat_dout <= dat_q.pop_front();
    req_empty <= (req_q.size() == 0);
    dat_empty <= (dat_q.size() == 0);
  end

  // ---------------- MISO driver: bit k of the transaction = word[31-k] -------
  logic [31:0] miso_word = 32'h0;
  int          miso_idx = 0;
  logic        drv_prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (cs_n == 4'hF) miso_idx = 0;
    else if (drv_prev_sclk && !sclk && miso_idx < 31) miso_idx = miso_idx + 1;
    drv_prev_sclk = sclk;
    miso = miso_word[31 - miso_idx];
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  cs;
    logic [7:0]  sclk;
    logic [31:0] mosi;
    logic [7:0]  status;
    logic [7:0]  rd;
    logic [7:0]  reads;
    logic [7:0]  hold;
    logic [7:0]  gaps;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_exp(input logic [3:0] cs, input int nsclk, input logic [31:0] m,
                          input logic [7:0] st, input logic [7:0] rd, input int reads,
                          input int hold, input int gaps);
    exp_t e;
    e.cs = cs; e.sclk = 8'(nsclk); e.mosi = m; e.status = st; e.rd = rd;
    e.reads = 8'(reads); e.hold = 8'(hold); e.gaps = 8'(gaps);
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int          cyc = 0;
  int          n_req_rd = 0, n_done = 0;
  int          last_req_rd_cyc = 0, last_done_cyc = 0;
  int          cs_high_run = 0, cs_gap_last = 0;
  logic        prev_sclk = 1'b0;
  logic [3:0]  prev_cs = 4'hF;
  logic [3:0]  o_cs = 4'hF;
  logic        o_cs_bad = 1'b0, o_bad_period = 1'b0;
  int          o_sclk = 0, o_reads = 0, o_gaps = 0, o_hold = 0, o_setup = 0;
  int          o_cs_low_cyc = 0, o_last_rise = 0, o_last_fall = 0, mon_d = 0;
  logic [31:0] o_mosi = 32'h0;
  exp_t        e_cur;

  task automatic mon_clear();
    o_cs = 4'hF; o_cs_bad = 1'b0; o_bad_period = 1'b0;
    o_sclk = 0; o_reads = 0; o_gaps = 0; o_hold = 0; o_setup = 0; o_mosi = 32'h0;
  endtask

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      mon_clear();
      prev_sclk = 1'b0;
      prev_cs = 4'hF;
      cs_high_run = 0;
    end else begin
      if (req_rd) begin n_req_rd = n_req_rd + 1; last_req_rd_cyc = cyc; end
      if (dat_rd) o_reads = o_reads + 1;
      if (cs_n != 4'hF) begin
        if (prev_cs == 4'hF) begin o_cs_low_cyc = cyc; cs_gap_last = cs_high_run; end
        if (o_cs == 4'hF) o_cs = cs_n;
        else if (cs_n != o_cs) o_cs_bad = 1'b1;
        if ($countones(~cs_n) != 1) o_cs_bad = 1'b1;
        cs_high_run = 0;
      end else begin
        cs_high_run = cs_high_run + 1;
      end
      if (sclk && !prev_sclk) begin
        if (o_sclk == 0) o_setup = cyc - o_cs_low_cyc;
        else begin
          mon_d = cyc - o_last_rise;
          if (mon_d == 2*CLK_DIV + 2) o_gaps = o_gaps + 1;
          else if (mon_d != 2*CLK_DIV) o_bad_period = 1'b1;
        end
        if (cs_n == 4'hF) o_cs_bad = 1'b1;
        o_last_rise = cyc;
        o_sclk = o_sclk + 1;
        o_mosi = {o_mosi[30:0], mosi};
      end
      if (!sclk && prev_sclk) o_last_fall = cyc;
      if (cs_n == 4'hF && prev_cs != 4'hF) o_hold = cyc - o_last_fall;
      if (done) begin
        n_done = n_done + 1;
        last_done_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e_cur = exp_q.pop_front();
          check("cs_value",   32'(o_cs),    32'(e_cur.cs));
          check("cs_stable",  32'(o_cs_bad), 32'd0);
          check("sclk_count", 32'(o_sclk),  32'(e_cur.sclk));
          check("mosi_bits",  o_mosi,       e_cur.mosi);
          check("status",     32'(status),  32'(e_cur.status));
          check("rd_data",    32'(rd_data), 32'(e_cur.rd));
          check("fifo_reads", 32'(o_reads), 32'(e_cur.reads));
          check("cs_hold",    32'(o_hold),  32'(e_cur.hold));
          check("cs_setup",   32'(o_setup), 32'(CLK_DIV));
          check("byte_gaps",  32'(o_gaps),  32'(e_cur.gaps));
          check("sclk_period", 32'(o_bad_period), 32'd0);
        end
        mon_clear();
      end
      prev_sclk = sclk;
      prev_cs = cs_n;
    end
  end

  task automatic drain(input string name, input int bound);
    for (int i = 0; i < bound && (exp_q.size() != 0 || busy); i++) @(posedge clk);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int base, rbase, saw_busy, bad_rd;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cs_n",  32'(cs_n),    32'hF);
    check("rst_sclk",  32'(sclk),    32'd0);
    check("rst_mosi",  32'(mosi),    32'd0);
    check("rst_rd_en", 32'({req_rd, dat_rd}), 32'd0);
    check("rst_rdata", 32'(rd_data), 32'd0);
    check("rst_done",  32'(done),    32'd0);
    check("rst_stat",  32'(status),  32'd0);
    check("rst_busy",  32'(busy),    32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1-byte request to device 0
    miso_word = 32'h3C00_0000;
    dat_q.push_back(8'hA5);
    req_q.push_back(8'h00);
    push_exp(4'hE, 8, 32'h0000_00A5, 8'h00, 8'h3C, 1, CLK_DIV, 0);
    spi_en = 1'b1;
    drain("single", 300);

    // 4-byte request to device 3
    miso_word = 32'hC33C_965A;
    dat_q.push_back(8'h01); dat_q.push_back(8'h02);
    dat_q.push_back(8'h03); dat_q.push_back(8'h04);
    req_q.push_back(8'hC3);
    push_exp(4'h7, 32, 32'h0102_0304, 8'h00, 8'h5A, 4, CLK_DIV, 3);
    drain("multi", 600);

    // underrun: 2 bytes requested, 1 available
    miso_word = 32'h8100_0000;
    dat_q.push_back(8'h3C);
    req_q.push_back(8'h01);
    push_exp(4'hE, 8, 32'h0000_003C, 8'hE1, 8'h81, 1, TIMEOUT, 0);
    drain("underrun", 400);

    // spi_en low holds off a queued request
    spi_en = 1'b0;
    miso_word = 32'h0;
    @(negedge clk);
    dat_q.push_back(8'h81); dat_q.push_back(8'h7E);
    req_q.push_back(8'h41);
    base = n_req_rd;
    saw_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    check("en_low_no_req_rd", 32'(n_req_rd - base), 32'd0);
    check("en_low_not_busy",  32'(saw_busy), 32'd0);
    check("en_low_data_kept", 32'(dat_q.size()), 32'd2);
    push_exp(4'hD, 16, 32'h0000_817E, 8'h00, 8'h00, 2, CLK_DIV, 1);
    spi_en = 1'b1;
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    spi_en = 1'b0;
    drain("en_drop", 400);

    // back-to-back requests
    miso_word = 32'hA500_0000;
    dat_q.push_back(8'hF0); dat_q.push_back(8'h0F);
    req_q.push_back(8'h80); req_q.push_back(8'h00);
    push_exp(4'hB, 8, 32'h0000_00F0, 8'h00, 8'hA5, 1, CLK_DIV, 0);
    push_exp(4'hE, 8, 32'h0000_000F, 8'h00, 8'hA5, 1, CLK_DIV, 0);
    base = n_done;
    spi_en = 1'b1;
    for (int i = 0; i < 300 && n_done == base; i++) @(posedge clk);
    check("b2b_first_done", 32'(n_done - base), 32'd1);
    rbase = n_req_rd;
    for (int i = 0; i < 20 && n_req_rd == rbase; i++) @(posedge clk);
    check("b2b_idle_gap", 32'(last_req_rd_cyc - last_done_cyc), 32'd1);
    drain("b2b", 400);
    check("b2b_cs_gap_ge_div", 32'(cs_gap_last >= CLK_DIV), 32'd1);

    // reset asserted at bit 4 of a byte
    miso_word = 32'h0;
    dat_q.push_back(8'hAA); dat_q.push_back(8'h55);
    req_q.push_back(8'h01); req_q.push_back(8'h00);
    for (int i = 0; i < 400 && o_sclk < 5; i++) @(posedge clk);
    check("rst_mid_reached_bit4", 32'(o_sclk), 32'd5);
    #3;
    rst = 1'b0;
    #1;
    check("rst_mid_cs_n", 32'(cs_n), 32'hF);
    check("rst_mid_sclk", 32'(sclk), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    bad_rd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req_rd || dat_rd) bad_rd = 1;
    end
    check("rst_mid_no_reads", 32'(bad_rd), 32'd0);
    check("rst_mid_data_left", 32'(dat_q.size()), 32'd1);
    check("rst_mid_rdata", 32'(rd_data), 32'd0);
    spi_en = 1'b0;
    rst = 1'b1;
    dat_q.delete();
    req_q.delete();
    repeat (3) @(negedge clk);
    check("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
